// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : Debounced board reset / SDRAM bring-up sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4_000_000,
    parameter int PULSE_CYCLES    = 16,
    parameter int CAL_TIMEOUT     = 100_000_000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_key_n,
    input  logic       i_cal_done,
    input  logic       i_cal_fail,
    output logic       o_global_reset_n,
    output logic       o_soft_reset_n,
    output logic       o_reset,
    output logic [2:0] o_state,
    output logic [7:0] o_restart_count
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PULSE_W = $clog2(PULSE_CYCLES) + 1;
    localparam int CAL_W   = $clog2(CAL_TIMEOUT) + 1;

    localparam logic [DB_W-1:0]    c_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] c_PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [CAL_W-1:0]   c_CAL_LAST   = CAL_W'(CAL_TIMEOUT - 1);

    // ST_BOOT only exists between reset release and the first edge, so the
    // reset-time outputs (both memory resets low) stay distinct from GLOBAL.
    typedef enum logic [2:0] {
        ST_GLOBAL   = 3'd0,
        ST_SOFT     = 3'd1,
        ST_WAIT_CAL = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4,
        ST_BOOT     = 3'd7
    } state_t;

    logic              r_key_meta;
    logic              r_key_sync;
    logic              r_key_level;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_press;

    state_t            r_state;
    state_t            w_next;
    logic [PULSE_W-1:0] r_pulse_cnt;
    logic [CAL_W-1:0]  r_cal_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= i_key_n;
            r_key_sync <= r_key_meta;
        end
    end

    // Press is registered, so it reaches the FSM one edge after acceptance.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_key_level <= 1'b1;
            r_db_cnt    <= '0;
            r_press     <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_key_sync == r_key_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_key_level <= r_key_sync;
                r_db_cnt    <= '0;
                r_press     <= ~r_key_sync;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BOOT:     w_next = ST_GLOBAL;
            ST_GLOBAL:   if (r_pulse_cnt == c_PULSE_LAST) w_next = ST_SOFT;
            ST_SOFT:     if (r_pulse_cnt == c_PULSE_LAST) w_next = ST_WAIT_CAL;
            ST_WAIT_CAL: begin
                if (i_cal_fail || (r_cal_cnt == c_CAL_LAST)) begin
                    w_next = ST_FAIL;
                end else if (i_cal_done) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN, ST_FAIL: if (r_press) w_next = ST_GLOBAL;
            default:     w_next = ST_GLOBAL;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state          <= ST_BOOT;
            r_pulse_cnt      <= '0;
            r_cal_cnt        <= '0;
            o_global_reset_n <= 1'b0;
            o_soft_reset_n   <= 1'b0;
            o_reset          <= 1'b1;
            o_state          <= 3'd0;
            o_restart_count  <= 8'd0;
        end else begin
            r_state <= w_next;
            o_state <= w_next;

            if (w_next != r_state) begin
                r_pulse_cnt <= '0;
            end else if ((r_state == ST_GLOBAL) || (r_state == ST_SOFT)) begin
                r_pulse_cnt <= r_pulse_cnt + PULSE_W'(1);
            end

            if ((r_state == ST_WAIT_CAL) && (w_next == ST_WAIT_CAL)) begin
                r_cal_cnt <= r_cal_cnt + CAL_W'(1);
            end else begin
                r_cal_cnt <= '0;
            end

            if (((r_state == ST_RUN) || (r_state == ST_FAIL)) && (w_next == ST_GLOBAL)) begin
                o_restart_count <= o_restart_count + 8'd1;
            end

            case (w_next)
                ST_GLOBAL: begin
                    o_global_reset_n <= 1'b0;
                    o_soft_reset_n   <= 1'b1;
                    o_reset          <= 1'b1;
                end
                ST_SOFT: begin
                    o_global_reset_n <= 1'b1;
                    o_soft_reset_n   <= 1'b0;
                    o_reset          <= 1'b1;
                end
                ST_RUN: begin
                    o_global_reset_n <= 1'b1;
                    o_soft_reset_n   <= 1'b1;
                    o_reset          <= 1'b0;
                end
                default: begin
                    o_global_reset_n <= 1'b1;
                    o_soft_reset_n   <= 1'b1;
                    o_reset          <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed vector bench for reset_sequencer (small parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int DB = 8;
    localparam int PC = 4;
    localparam int CT = 32;

    // {global_n, soft_n, reset, state[2:0]}
    localparam logic [5:0] c_E_RST  = 6'b001_000;
    localparam logic [5:0] c_E_GLB  = 6'b011_000;
    localparam logic [5:0] c_E_SOFT = 6'b101_001;
    localparam logic [5:0] c_E_WAIT = 6'b111_010;
    localparam logic [5:0] c_E_RUN  = 6'b110_011;
    localparam logic [5:0] c_E_FAIL = 6'b111_100;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       key_n    = 1'b1;
    logic       cal_done = 1'b0;
    logic       cal_fail = 1'b0;
    logic       g_n;
    logic       s_n;
    logic       rst_out;
    logic [2:0] st;
    logic [7:0] rcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC),
        .CAL_TIMEOUT     (CT)
    ) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_key_n          (key_n),
        .i_cal_done       (cal_done),
        .i_cal_fail       (cal_fail),
        .o_global_reset_n (g_n),
        .o_soft_reset_n   (s_n),
        .o_reset          (rst_out),
        .o_state          (st),
        .o_restart_count  (rcnt)
    );

    typedef struct {
        bit         restart;
        logic       cd;
        logic       cf;
        logic [5:0] want;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_n = 1'b1;
        cycle(2);
        check("reset_outputs", {26'd0, g_n, s_n, rst_out, st}, {26'd0, c_E_RST});
        check("reset_count", {24'd0, rcnt}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].restart) do_reset();
            cal_done = vecs[i].cd;
            cal_fail = vecs[i].cf;
            cycle(1);
            check($sformatf("vec%0d", i), {26'd0, g_n, s_n, rst_out, st}, {26'd0, vecs[i].want});
        end
    endtask

    function automatic vec_t mk(input bit r, input logic cd, input logic cf, input logic [5:0] w);
        vec_t v;
        v.restart = r;
        v.cd      = cd;
        v.cf      = cf;
        v.want    = w;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_low;

        // Power-up with calibration already done: edges 1..11 after release.
        vecs[0] = mk(1'b1, 1'b1, 1'b0, c_E_GLB);
        for (int i = 1; i <= 3; i++) vecs[i] = mk(1'b0, 1'b1, 1'b0, c_E_GLB);
        for (int i = 4; i <= 7; i++) vecs[i] = mk(1'b0, 1'b1, 1'b0, c_E_SOFT);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, c_E_WAIT);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, c_E_RUN);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, c_E_RUN);
        // done and fail together on the first WAIT_CAL sample: FAIL wins.
        vecs[11] = mk(1'b1, 1'b0, 1'b0, c_E_GLB);
        for (int i = 12; i <= 14; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, c_E_GLB);
        for (int i = 15; i <= 18; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, c_E_SOFT);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, c_E_WAIT);
        vecs[20] = mk(1'b0, 1'b1, 1'b1, c_E_FAIL);
        vecs[21] = mk(1'b0, 1'b1, 1'b0, c_E_FAIL);
        vecs[22] = mk(1'b0, 1'b1, 1'b0, c_E_FAIL);

        @(negedge clk);
        run_vectors(0, 10);

        // Short press and bounce in RUN: no event.
        seen_low = 1'b0;
        key_n = 1'b0; for (int i = 0; i < 5; i++) begin cycle(1); seen_low |= ~g_n; end
        key_n = 1'b1; cycle(1); seen_low |= ~g_n;
        key_n = 1'b0; for (int i = 0; i < 3; i++) begin cycle(1); seen_low |= ~g_n; end
        key_n = 1'b1; for (int i = 0; i < 12; i++) begin cycle(1); seen_low |= ~g_n; end
        check("bounce_no_global", {31'd0, seen_low}, 32'd0);
        check("bounce_state", {29'd0, st}, 32'd3);
        check("bounce_count", {24'd0, rcnt}, 32'd0);

        // Held press: global_n falls on edge DB+3.
        key_n = 1'b0;
        cycle(10);
        check("press_edge10_global", {31'd0, g_n}, 32'd1);
        cycle(1);
        check("press_edge11_global", {31'd0, g_n}, 32'd0);
        check("press_state", {29'd0, st}, 32'd0);
        check("press_count", {24'd0, rcnt}, 32'd1);
        cycle(9);
        check("rerun_state", {29'd0, st}, 32'd3);
        check("rerun_reset", {31'd0, rst_out}, 32'd0);
        key_n = 1'b1;
        cycle(15);
        check("release_state", {29'd0, st}, 32'd3);
        check("release_count", {24'd0, rcnt}, 32'd1);

        run_vectors(11, 22);

        // Press landing in WAIT_CAL is dropped.
        cal_done = 1'b0;
        cal_fail = 1'b0;
        do_reset();
        key_n = 1'b0;
        cycle(9);
        check("drop_wait_entry", {29'd0, st}, 32'd2);
        cycle(2);
        check("drop_state", {29'd0, st}, 32'd2);
        check("drop_global", {31'd0, g_n}, 32'd1);
        key_n = 1'b1;
        cal_done = 1'b1;
        cycle(1);
        check("drop_run", {29'd0, st}, 32'd3);
        cycle(15);
        check("drop_run_late", {29'd0, st}, 32'd3);
        check("drop_count", {24'd0, rcnt}, 32'd0);

        // Calibration timeout, then restart out of FAIL.
        cal_done = 1'b0;
        do_reset();
        cycle(40);
        check("timeout_edge40", {29'd0, st}, 32'd2);
        cycle(1);
        check("timeout_edge41", {29'd0, st}, 32'd4);
        check("timeout_reset", {31'd0, rst_out}, 32'd1);
        cycle(5);
        check("fail_hold", {29'd0, st}, 32'd4);
        key_n = 1'b0;
        cycle(11);
        check("fail_restart_state", {29'd0, st}, 32'd0);
        check("fail_restart_global", {31'd0, g_n}, 32'd0);
        check("fail_restart_count", {24'd0, rcnt}, 32'd1);
        key_n = 1'b1;

        // Asynchronous reset in the middle of SOFT.
        cal_done = 1'b1;
        do_reset();
        cycle(6);
        check("midsoft_state", {29'd0, st}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("midsoft_async", {18'd0, g_n, s_n, rst_out, st, rcnt}, {18'd0, c_E_RST, 8'd0});
        @(negedge clk);
        run_vectors(0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
